// File: rtl/mod5_pkg.sv
// mod5_pkg: constants shared by the serial mod-5 transmitter and the
// matching checking receivers: the IDLE/DATA/CHECK state encodings, the
// check modulus, the residue/accumulator width and the number of check
// bits appended to each frame.
package mod5_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam int unsigned MOD         = 5;
    localparam int unsigned RES_W       = 3;
    localparam int unsigned TRAILER_LEN = 3;

endpackage

// File: rtl/mod5_step.sv
// mod5_step: one MSB-first step of a running mod-5 residue.
//   acc      : current residue, 0..4
//   b        : next serial bit
//   acc_next : (2*acc + b) mod 5
module mod5_step
    import mod5_pkg::*;
(
    input  logic [RES_W-1:0] acc,
    input  logic             b,
    output logic [RES_W-1:0] acc_next
);

    logic [RES_W:0] sum;
    logic [RES_W:0] diff;

    // 2*acc+b is at most 9, so a single conditional subtract reduces it.
    always_comb begin
        sum  = {acc, b};
        diff = sum - (RES_W+1)'(MOD);
        if (sum >= (RES_W+1)'(MOD)) begin
            acc_next = diff[RES_W-1:0];
        end else begin
            acc_next = sum[RES_W-1:0];
        end
    end

endmodule

// File: rtl/serial_mod5_tx.sv
// serial_mod5_tx: shifts a WIDTH-bit word out MSB first, then appends the
// word's mod-5 residue as a 3-bit trailer, LSB first.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   load, din  : start request and word; taken on an edge where ready=1
//   ready      : a load is accepted this cycle (idle or final trailer bit)
//   tx_bit     : serial data (0 when tx_valid=0)
//   tx_valid   : tx_bit carries a frame bit
//   tx_last    : tx_bit is the final trailer bit
//   residue    : din mod 5 of the most recent frame
module serial_mod5_tx
    import mod5_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             tx_last,
    output logic [RES_W-1:0] residue
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] shreg_q,    shreg_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [1:0]       tidx_q,     tidx_d;
    logic [RES_W-1:0] acc_q,      acc_d;
    logic [RES_W-1:0] residue_q,  residue_d;
    logic             tx_bit_q,   tx_bit_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_last_q,  tx_last_d;
    logic             ready_q,    ready_d;

    logic             accept;
    logic [RES_W-1:0] step_acc;
    logic             step_b;
    logic             step_next_unused;
    logic [RES_W-1:0] step_next;

    mod5_step u_step (
        .acc      (step_acc),
        .b        (step_b),
        .acc_next (step_next)
    );

    assign step_next_unused = 1'b0;

    // acc_q always covers every bit already on tx_bit, so the accepting
    // edge folds din[MSB] into acc (starting from 0) as it presents it, and
    // the din[0] cycle already holds the final residue.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        tidx_d     = tidx_q;
        acc_d      = acc_q;
        residue_d  = residue_q;
        tx_bit_d   = 1'b0;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        ready_d    = 1'b0;
        accept     = ready_q & load;
        step_acc   = acc_q;
        step_b     = shreg_q[WIDTH-1];

        if (accept) begin
            step_acc   = '0;
            step_b     = din[WIDTH-1];
            state_d    = DATA;
            shreg_d    = {din[WIDTH-2:0], 1'b0};
            cnt_d      = CNT_W'(WIDTH - 1);
            acc_d      = step_next;
            tx_bit_d   = din[WIDTH-1];
            tx_valid_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_d = 1'b1;
                end
                DATA: begin
                    tx_valid_d = 1'b1;
                    if (cnt_q != '0) begin
                        tx_bit_d = shreg_q[WIDTH-1];
                        shreg_d  = shreg_q << 1;
                        acc_d    = step_next;
                        cnt_d    = cnt_q - 1'b1;
                    end else begin
                        residue_d = acc_q;
                        tx_bit_d  = acc_q[0];
                        tidx_d    = '0;
                        state_d   = CHECK;
                    end
                end
                CHECK: begin
                    if (tidx_q == 2'(TRAILER_LEN - 1)) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end else begin
                        tx_valid_d = 1'b1;
                        tidx_d     = tidx_q + 1'b1;
                        tx_bit_d   = residue_q[tidx_d];
                        if (tidx_d == 2'(TRAILER_LEN - 1)) begin
                            tx_last_d = 1'b1;
                            ready_d   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            tidx_q     <= '0;
            acc_q      <= '0;
            residue_q  <= '0;
            tx_bit_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            tidx_q     <= tidx_d;
            acc_q      <= acc_d;
            residue_q  <= residue_d;
            tx_bit_q   <= tx_bit_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            ready_q    <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign tx_bit   = tx_bit_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign residue  = residue_q;

endmodule

// File: tb/tb_serial_mod5_tx.sv
// tb_serial_mod5_tx: drives serial_mod5_tx with directed and random frames
// and compares every cycle against a bit-queue model of the frame format.
module tb_serial_mod5_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] din;
    logic         ready;
    logic         tx_bit;
    logic         tx_valid;
    logic         tx_last;
    logic [2:0]   residue;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       b;
        logic       last;
        logic       first_trl;
        logic [2:0] res;
    } exp_t;

    exp_t       q[$];
    logic [2:0] exp_res;

    serial_mod5_tx #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .din      (din),
        .ready    (ready),
        .tx_bit   (tx_bit),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .residue  (residue)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame = data bits MSB first, then (d mod 5) LSB first.
    task automatic push_frame(input logic [W-1:0] d);
        exp_t e;
        int   r;
        r = int'(d) % 5;
        for (int i = W - 1; i >= 0; i--) begin
            e = '{b: d[i], last: 1'b0, first_trl: 1'b0, res: 3'd0};
            q.push_back(e);
        end
        for (int i = 0; i < 3; i++) begin
            e = '{b: r[i], last: (i == 2), first_trl: (i == 0), res: 3'(r)};
            q.push_back(e);
        end
    endtask

    task automatic observe();
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("tx_valid", 32'(tx_valid), 32'd1);
            check("tx_bit", 32'(tx_bit), 32'(e.b));
            check("tx_last", 32'(tx_last), 32'(e.last));
            if (e.first_trl) exp_res = e.res;
        end else begin
            check("idle_valid", 32'(tx_valid), 32'd0);
            check("idle_bit", 32'(tx_bit), 32'd0);
            check("idle_last", 32'(tx_last), 32'd0);
        end
        // Ready exactly when idle or on the last trailer bit.
        check("ready", 32'(ready), 32'(q.size() == 0));
        check("residue", 32'(residue), 32'(exp_res));
    endtask

    // Called just after a negedge; applies inputs for the next rising edge.
    task automatic step(input logic ld, input logic [W-1:0] d);
        load = ld;
        din  = d;
        if (ld && q.size() == 0) push_frame(d);
        @(posedge clk);
        @(negedge clk);
        observe();
    endtask

    task automatic drain();
        repeat (W + 4) step(1'b0, W'($urandom));
    endtask

    int frames;

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        din     = '0;
        exp_res = 3'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_bit", 32'(tx_bit), 32'd0);
        check("rst_last", 32'(tx_last), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_residue", 32'(residue), 32'd0);
        reset = 1'b0;

        // Single frame 0x1B.
        step(1'b1, 8'h1B);
        drain();
        check("res_1b", 32'(residue), 32'd2);

        // Back-to-back frames with load held high.
        step(1'b1, 8'h1F);
        repeat (W + 2) step(1'b1, 8'h1F);
        check("res_1f", 32'(residue), 32'd1);
        step(1'b1, 8'hD6);
        check("b2b_accept", 32'(q.size()), 32'(W + 2));
        load = 1'b0;
        drain();
        check("res_d6", 32'(residue), 32'd4);

        // Zero residue, then all-zero frame.
        step(1'b1, 8'hFF);
        drain();
        check("res_ff", 32'(residue), 32'd0);
        step(1'b1, 8'h00);
        drain();

        // Load pulse mid-frame must be ignored.
        step(1'b1, 8'h3C);
        repeat (2) step(1'b0, 8'h00);
        step(1'b1, 8'hAA);
        drain();

        // Asynchronous reset during trailer bit 1, with load high at the edge.
        step(1'b1, 8'h1B);
        repeat (W + 1) step(1'b0, 8'h00);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 32'(tx_valid), 32'd0);
        check("arst_bit", 32'(tx_bit), 32'd0);
        check("arst_last", 32'(tx_last), 32'd0);
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_residue", 32'(residue), 32'd0);
        q.delete();
        exp_res = 3'd0;
        load = 1'b1;
        din  = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        observe();
        step(1'b1, 8'h1B);
        drain();
        check("res_1b_after_rst", 32'(residue), 32'd2);

        // Random frames with and without gaps.
        frames = 0;
        while (frames < 200) begin
            logic ld;
            ld = ($urandom_range(0, 3) != 0);
            if (ld && q.size() == 0) frames++;
            step(ld, W'($urandom));
        end
        drain();
        check("drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
